// File: rtl/processor_switch_arbiter_pkg.sv
// Shared types for the two-processor switch arbiter: FSM encoding,
// processor indices and the bundled memory request.
package processor_switch_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_START = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_SWAP  = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    localparam logic P_SYS  = 1'b0;
    localparam logic P_GAME = 1'b1;

    typedef struct packed {
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } mem_req_t;

endpackage

// File: rtl/processor_switch_arbiter_mem_port_mux.sv
// 2:1 memory request mux; without a valid grant the bus is forced to all zeros
// so a disabled processor can never reach the memory controller.
module mem_port_mux
    import processor_switch_arbiter_pkg::*;
(
    input  logic     sel_i,
    input  logic     grant_valid_i,
    input  mem_req_t p0_i,
    input  mem_req_t p1_i,
    output mem_req_t mem_o
);

    always_comb begin
        mem_o = '0;
        if (grant_valid_i) begin
            mem_o = sel_i ? p1_i : p0_i;
        end
    end

endmodule

// File: rtl/processor_switch_arbiter.sv
// Hands the shared memory port and run enables between the system (P0) and
// game (P1) processors, with a bus drain on every handover and a sticky fatal halt.
//
// state    | meaning
// ST_START | one cycle with everything disabled after reset
// ST_RUN   | ACTIVE processor enabled and owns the memory port
// ST_DRAIN | both disabled, bus idle, DRAIN_CYCLES cycles
// ST_SWAP  | one cycle, flip ACTIVE and count the handover
// ST_HALT  | fatal error seen, everything disabled until reset
module processor_switch_arbiter
    import processor_switch_arbiter_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int MIN_RUN      = 16,
    parameter int CNT_W        = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    output logic             P0_ENABLE,
    input  logic             P0_SWITCH_REQ,
    input  logic             P0_FATAL,
    input  logic             P0_MEM_ENABLE,
    input  logic             P0_MEM_WRITE,
    input  logic [15:0]      P0_MEM_ADDR,
    input  logic [15:0]      P0_MEM_DATA_W,
    output logic             P1_ENABLE,
    input  logic             P1_SWITCH_REQ,
    input  logic             P1_FATAL,
    input  logic             P1_MEM_ENABLE,
    input  logic             P1_MEM_WRITE,
    input  logic [15:0]      P1_MEM_ADDR,
    input  logic [15:0]      P1_MEM_DATA_W,
    output logic             MEM_ENABLE,
    output logic             MEM_WRITE,
    output logic [15:0]      MEM_ADDR,
    output logic [15:0]      MEM_DATA_W,
    output logic             ACTIVE,
    output logic             HALTED,
    output logic             ERROR_SRC,
    output logic [CNT_W-1:0] SWITCH_COUNT
);

    // One counter serves both the minimum-run and the drain timing.
    localparam int CTR_MAX = (MIN_RUN > DRAIN_CYCLES) ? MIN_RUN : DRAIN_CYCLES;
    localparam int CTR_W   = $clog2(CTR_MAX + 1);
    localparam logic [CTR_W-1:0] MIN_RUN_C    = CTR_W'(MIN_RUN);
    localparam logic [CTR_W-1:0] DRAIN_LAST_C = CTR_W'(DRAIN_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CTR_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;
    logic             halted_q, halted_d;
    logic             err_src_q, err_src_d;
    logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;

    logic     grant;
    logic     sw_req_act;
    logic     fatal_act;
    mem_req_t p0_req, p1_req, mem_req;

    assign sw_req_act = (active_q == P_GAME) ? P1_SWITCH_REQ : P0_SWITCH_REQ;
    assign fatal_act  = (active_q == P_GAME) ? P1_FATAL      : P0_FATAL;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q   <= ST_START;
            cnt_q     <= '0;
            active_q  <= P_SYS;
            halted_q  <= 1'b0;
            err_src_q <= 1'b0;
            sw_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            halted_q  <= halted_d;
            err_src_q <= err_src_d;
            sw_cnt_q  <= sw_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        halted_d  = halted_q;
        err_src_d = err_src_q;
        sw_cnt_d  = sw_cnt_q;
        case (state_q)
            ST_START: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
            ST_RUN: begin
                if (fatal_act) begin
                    state_d   = ST_HALT;
                    halted_d  = 1'b1;
                    err_src_d = active_q;
                end else if (sw_req_act && (cnt_q >= MIN_RUN_C)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else if (cnt_q < MIN_RUN_C) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt_q >= DRAIN_LAST_C) begin
                    state_d = ST_SWAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SWAP: begin
                state_d  = ST_RUN;
                active_d = ~active_q;
                sw_cnt_d = sw_cnt_q + 1'b1;
                cnt_d    = '0;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_START;
        endcase
    end

    always_comb begin
        grant     = (state_q == ST_RUN);
        P0_ENABLE = grant && (active_q == P_SYS);
        P1_ENABLE = grant && (active_q == P_GAME);
    end

    assign p0_req = {P0_MEM_ENABLE, P0_MEM_WRITE, P0_MEM_ADDR, P0_MEM_DATA_W};
    assign p1_req = {P1_MEM_ENABLE, P1_MEM_WRITE, P1_MEM_ADDR, P1_MEM_DATA_W};

    mem_port_mux u_mem_port_mux (
        .sel_i         (active_q),
        .grant_valid_i (grant),
        .p0_i          (p0_req),
        .p1_i          (p1_req),
        .mem_o         (mem_req)
    );

    assign MEM_ENABLE   = mem_req.en;
    assign MEM_WRITE    = mem_req.wr;
    assign MEM_ADDR     = mem_req.addr;
    assign MEM_DATA_W   = mem_req.data;
    assign ACTIVE       = active_q;
    assign HALTED       = halted_q;
    assign ERROR_SRC    = err_src_q;
    assign SWITCH_COUNT = sw_cnt_q;

endmodule

// File: tb/tb_processor_switch_arbiter.sv
// Randomized bench for processor_switch_arbiter against a cycle-level model
// of run tenure, drain gap, handover count and fatal halt.
module tb_processor_switch_arbiter;

    localparam int DRAIN = 4;
    localparam int MINR  = 16;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        p0_sw = 0, p0_fatal = 0, p0_men = 0, p0_mwr = 0;
    logic [15:0] p0_addr = 0, p0_data = 0;
    logic        p1_sw = 0, p1_fatal = 0, p1_men = 0, p1_mwr = 0;
    logic [15:0] p1_addr = 0, p1_data = 0;

    logic        p0_en, p1_en, mem_en, mem_wr, active, halted, err_src;
    logic [15:0] mem_addr, mem_data;
    logic [7:0]  sw_count;
    logic        p0_en2, p1_en2, mem_en2, mem_wr2, active2, halted2, err_src2;
    logic [15:0] mem_addr2, mem_data2;
    logic [1:0]  sw_count2;

    always #5 CLK = ~CLK;

    processor_switch_arbiter #(.DRAIN_CYCLES(DRAIN), .MIN_RUN(MINR), .CNT_W(8)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .P0_ENABLE(p0_en), .P0_SWITCH_REQ(p0_sw), .P0_FATAL(p0_fatal),
        .P0_MEM_ENABLE(p0_men), .P0_MEM_WRITE(p0_mwr), .P0_MEM_ADDR(p0_addr), .P0_MEM_DATA_W(p0_data),
        .P1_ENABLE(p1_en), .P1_SWITCH_REQ(p1_sw), .P1_FATAL(p1_fatal),
        .P1_MEM_ENABLE(p1_men), .P1_MEM_WRITE(p1_mwr), .P1_MEM_ADDR(p1_addr), .P1_MEM_DATA_W(p1_data),
        .MEM_ENABLE(mem_en), .MEM_WRITE(mem_wr), .MEM_ADDR(mem_addr), .MEM_DATA_W(mem_data),
        .ACTIVE(active), .HALTED(halted), .ERROR_SRC(err_src), .SWITCH_COUNT(sw_count)
    );

    processor_switch_arbiter #(.DRAIN_CYCLES(DRAIN), .MIN_RUN(MINR), .CNT_W(2)) dut2 (
        .CLK(CLK), .RESET_N(RESET_N),
        .P0_ENABLE(p0_en2), .P0_SWITCH_REQ(p0_sw), .P0_FATAL(p0_fatal),
        .P0_MEM_ENABLE(p0_men), .P0_MEM_WRITE(p0_mwr), .P0_MEM_ADDR(p0_addr), .P0_MEM_DATA_W(p0_data),
        .P1_ENABLE(p1_en2), .P1_SWITCH_REQ(p1_sw), .P1_FATAL(p1_fatal),
        .P1_MEM_ENABLE(p1_men), .P1_MEM_WRITE(p1_mwr), .P1_MEM_ADDR(p1_addr), .P1_MEM_DATA_W(p1_data),
        .MEM_ENABLE(mem_en2), .MEM_WRITE(mem_wr2), .MEM_ADDR(mem_addr2), .MEM_DATA_W(mem_data2),
        .ACTIVE(active2), .HALTED(halted2), .ERROR_SRC(err_src2), .SWITCH_COUNT(sw_count2)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model: m_off counts remaining disabled cycles (START or drain+swap gap),
    // m_run counts edges spent running in the current tenure.
    bit m_valid = 0, m_halted = 0, m_err = 0, m_active = 0, m_pend = 0;
    int m_off = 0, m_run = 0, m_count = 0;
    bit fix_addr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input int sw_pct, input int fatal_pct);
        bit a_sw, a_fatal;
        a_sw    = ($urandom_range(99) < sw_pct);
        a_fatal = ($urandom_range(99) < fatal_pct);
        p0_men = 1'($urandom); p0_mwr = 1'($urandom);
        p0_addr = 16'($urandom); p0_data = 16'($urandom);
        p1_men = 1'($urandom); p1_mwr = 1'($urandom);
        p1_addr = 16'($urandom); p1_data = 16'($urandom);
        if (fix_addr) p0_addr = 16'h1234;
        // The inactive processor gets random request/fatal noise every cycle.
        if (m_active) begin
            p1_sw = a_sw; p1_fatal = a_fatal;
            p0_sw = 1'($urandom); p0_fatal = 1'($urandom);
        end else begin
            p0_sw = a_sw; p0_fatal = a_fatal;
            p1_sw = 1'($urandom); p1_fatal = 1'($urandom);
        end
    endtask

    task automatic check_outputs();
        bit run;
        logic        e_en, e_wr;
        logic [15:0] e_addr, e_data;
        run = !m_halted && (m_off == 0);
        e_en = 0; e_wr = 0; e_addr = 0; e_data = 0;
        if (run) begin
            e_en   = m_active ? p1_men  : p0_men;
            e_wr   = m_active ? p1_mwr  : p0_mwr;
            e_addr = m_active ? p1_addr : p0_addr;
            e_data = m_active ? p1_data : p0_data;
        end
        chk("p0_enable", 32'(p0_en), 32'(run && !m_active));
        chk("p1_enable", 32'(p1_en), 32'(run && m_active));
        chk("mem_enable", 32'(mem_en), 32'(e_en));
        chk("mem_write", 32'(mem_wr), 32'(e_wr));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_data", 32'(mem_data), 32'(e_data));
        chk("active", 32'(active), 32'(m_active));
        chk("halted", 32'(halted), 32'(m_halted));
        chk("error_src", 32'(err_src), 32'(m_err));
        chk("switch_count", 32'(sw_count), 32'(m_count % 256));
        chk("switch_count_w2", 32'(sw_count2), 32'(m_count % 4));
        chk("p0_enable_w2", 32'(p0_en2), 32'(run && !m_active));
    endtask

    task automatic model_step();
        bit a_sw, a_fatal;
        a_sw    = m_active ? p1_sw    : p0_sw;
        a_fatal = m_active ? p1_fatal : p0_fatal;
        if (!RESET_N) begin
            m_valid = 1; m_halted = 0; m_err = 0; m_active = 0; m_pend = 0;
            m_off = 1; m_run = 0; m_count = 0;
        end else if (!m_valid || m_halted) begin
            // halted state is sticky
        end else if (m_off > 0) begin
            m_off--;
            if (m_off == 0) begin
                m_run = 0;
                if (m_pend) begin
                    m_active = !m_active;
                    m_count++;
                    m_pend = 0;
                end
            end
        end else if (a_fatal) begin
            m_halted = 1;
            m_err = m_active;
        end else if (a_sw && m_run >= MINR) begin
            m_off = DRAIN + 1;
            m_pend = 1;
        end else begin
            m_run++;
        end
    endtask

    task automatic cycle(input bit rst, input int sw_pct, input int fatal_pct);
        @(negedge CLK);
        RESET_N = !rst;
        drive(sw_pct, fatal_pct);
        #1;
        if (m_valid) check_outputs();
        @(posedge CLK);
        model_step();
    endtask

    task automatic do_reset();
        cycle(1, 0, 0);
        cycle(1, 0, 0);
    endtask

    initial begin
        int guard;

        // Bring-up: START then P0 owns the bus, fixed address seen same cycle.
        do_reset();
        fix_addr = 1;
        repeat (3) cycle(0, 0, 0);
        fix_addr = 0;

        // Early one-cycle pulse at run cycle 3 must be dropped.
        do_reset();
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 100, 0);
        repeat (20) cycle(0, 0, 0);

        // Request held from cycle 20: drain, swap, P1 runs.
        do_reset();
        repeat (19) cycle(0, 0, 0);
        repeat (40) cycle(0, 100, 0);

        // Reset during the second drain cycle.
        do_reset();
        guard = 0;
        while (!(m_off == DRAIN && m_pend) && guard < 100) begin
            cycle(0, 100, 0);
            guard++;
        end
        if (guard >= 100) chk("drain_reach_timeout", 32'(guard), 32'(0));
        cycle(1, 0, 0);
        repeat (5) cycle(0, 0, 0);

        // P1 running, fatal and switch on the same edge, then input noise.
        do_reset();
        guard = 0;
        while (!(m_active && m_off == 0 && m_run >= MINR) && guard < 200) begin
            cycle(0, 100, 0);
            guard++;
        end
        if (guard >= 200) chk("p1_run_timeout", 32'(guard), 32'(0));
        cycle(0, 100, 100);
        repeat (100) cycle(0, 50, 50);

        // Random traffic with frequent handovers and rare fatals.
        for (int rep = 0; rep < 4; rep++) begin
            do_reset();
            repeat (300) cycle(0, 15, (rep == 0) ? 0 : 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
